svm_weight_loader: RTL and testbench

//  Write side of the SVM weight RAM (port A); svm_ctrl reads the same RAM on port B.

---
 rtl/svm_pkg.sv | 13 +
 rtl/svm_byte_pack.sv | 51 +++++
 rtl/svm_weight_loader.sv | 116 +++++++++++
 tb/tb_svm_weight_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared SVM definitions: weight RAM geometry and loader FSM state codes.
// svm_ctrl relies on the same ADDR_W and MAX_ADDR for its port-B reads.
package svm_pkg;
  localparam int NUM_WORDS = 37;
  localparam int MAX_ADDR  = NUM_WORDS - 1;
  localparam int ADDR_W    = $clog2(NUM_WORDS);

  typedef logic [1:0] ld_state_t;
  localparam ld_state_t ST_IDLE  = 2'd0;
  localparam ld_state_t ST_LOAD  = 2'd1;
  localparam ld_state_t ST_CHECK = 2'd2;
  localparam ld_state_t ST_FIN   = 2'd3;
endpackage

// File: rtl/svm_byte_pack.sv
// Packs a little-endian byte stream into DATA_W-bit words.
// Latency: word/word_rdy one cycle after the last byte is taken; no backpressure (caller gates take).
module svm_byte_pack #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              take,
  input  logic [7:0]        data,
  output logic              last,
  output logic              word_rdy,
  output logic [DATA_W-1:0] word
);
  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] data_ext;
  logic [DATA_W-1:0] shifted;

  // New bytes enter at the top, so the first byte of a word ends up in [7:0].
  assign data_ext = DATA_W'(data);
  assign shifted  = (sreg >> 8) | (data_ext << (DATA_W - 8));
  assign last     = (byte_cnt == CNT_W'(BPW - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt <= '0;
      sreg     <= '0;
      word     <= '0;
      word_rdy <= 1'b0;
    end else begin
      word_rdy <= 1'b0;
      if (clr) begin
        byte_cnt <= '0;
        sreg     <= '0;
      end else if (take) begin
        sreg <= shifted;
        if (last) begin
          byte_cnt <= '0;
          word     <= shifted;
          word_rdy <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/svm_weight_loader.sv
// Loads NUM_WORDS weight/bias words into SVM RAM port A; optional checksum byte (SVM_LOAD_CHECKSUM_EN).
// Latency: RAM write one cycle after a word's last byte; done one cycle after the final write.
// Backpressure: o_ready only in LOAD (and CHECK); dropped while the final word is being written.
module svm_weight_loader
  import svm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] din_a,
  output logic              busy,
  output logic              done,
  output logic              w_valid,
  output logic              err
);
  ld_state_t         state, state_nx;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word;
  logic              word_rdy, pack_last, load_rdy, take, pack_take, last_wr, begin_load;

  assign begin_load = (state == ST_IDLE) && start;
  // All words accepted: stop taking bytes until the last write has gone out.
  assign load_rdy   = (state == ST_LOAD) && (word_cnt != ADDR_W'(NUM_WORDS));
`ifdef SVM_LOAD_CHECKSUM_EN
  assign o_ready    = load_rdy || (state == ST_CHECK);
`else
  assign o_ready    = load_rdy;
`endif
  assign take       = i_valid && o_ready;
  assign pack_take  = take && load_rdy;
  assign last_wr    = word_rdy && (addr_q == ADDR_W'(MAX_ADDR));

  assign we_a   = word_rdy;
  assign addr_a = addr_q;
  assign din_a  = word;
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_FIN);

  svm_byte_pack #(.DATA_W(DATA_W)) u_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (begin_load),
    .take     (pack_take),
    .data     (i_data),
    .last     (pack_last),
    .word_rdy (word_rdy),
    .word     (word)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
`ifdef SVM_LOAD_CHECKSUM_EN
      ST_LOAD:  if (last_wr) state_nx = ST_CHECK;
      ST_CHECK: if (take) state_nx = ST_FIN;
`else
      ST_LOAD:  if (last_wr) state_nx = ST_FIN;
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef SVM_LOAD_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign csum_ok = (i_data == csum);

  always_ff @(posedge clk) begin
    if (!rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (begin_load) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (pack_take) csum <= csum ^ i_data;
      if ((state == ST_CHECK) && take) err <= !csum_ok;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      addr_q   <= '0;
      w_valid  <= 1'b0;
    end else begin
      state <= state_nx;
      if (begin_load) begin
        word_cnt <= '0;
        w_valid  <= 1'b0;
      end
      if (pack_take && pack_last) begin
        addr_q   <= word_cnt;
        word_cnt <= word_cnt + 1'b1;
      end
`ifdef SVM_LOAD_CHECKSUM_EN
      if ((state == ST_CHECK) && take) w_valid <= csum_ok;
`else
      if ((state == ST_LOAD) && last_wr) w_valid <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_svm_weight_loader.sv
// Directed bench for svm_weight_loader against a byte-stream model of the expected RAM writes.
// Checksum cases are built only when SVM_LOAD_CHECKSUM_EN is defined.
module tb_svm_weight_loader;
  import svm_pkg::*;

  localparam int DATA_W = 16;
  localparam int BPW    = DATA_W / 8;
  localparam int NB     = NUM_WORDS * BPW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        i_data = 8'h00;
  logic              i_valid = 1'b0;
  logic              o_ready, we_a, busy, done, w_valid, err;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] din_a;

  svm_weight_loader #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .busy(busy), .done(done), .w_valid(w_valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: every accepted payload byte lands in its little-endian slot; a full word becomes an expected write.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        m_word;
  logic [7:0]               m_xor;
  int                       m_nbytes, m_idx;

  int                wr_cnt, done_cnt;
  logic [ADDR_W-1:0] first_addr, last_addr;
  logic [DATA_W-1:0] first_din, last_din;
  bit                prev_last_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_take(input logic [7:0] b);
    int pos;
    pos = m_nbytes % BPW;
    m_word[8*pos +: 8] = b;
    m_xor = m_xor ^ b;
    m_nbytes++;
    if (pos == BPW - 1) begin
      exp_q.push_back({ADDR_W'(m_idx), m_word});
      m_idx++;
    end
  endtask

  initial begin
    logic [ADDR_W+DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_last_we = 1'b0;
      end else begin
        if (we_a) begin
          wr_cnt++;
          if (wr_cnt == 1) begin first_addr = addr_a; first_din = din_a; end
          last_addr = addr_a;
          last_din  = din_a;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {1'b1, addr_a}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", addr_a, e[DATA_W +: ADDR_W]);
            chk("wr_din", din_a, e[DATA_W-1:0]);
          end
        end
        if (o_ready && !busy) chk("ready_while_idle", o_ready, 0);
        if (done) done_cnt++;
`ifndef SVM_LOAD_CHECKSUM_EN
        chk("done_timing", done, prev_last_we);
`endif
        prev_last_we = we_a && (addr_a == ADDR_W'(MAX_ADDR));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit payload);
    bit acc;
    acc = 1'b0;
    i_data  = b;
    i_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_ready) begin
        acc = 1'b1;
        if (payload) model_take(b);
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    i_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 0, 1);
  endtask

  // csum_sel: 0 none, 1 correct checksum byte, 2 corrupted checksum byte
  task automatic run_load(input int gap_mode, input int extra_start_k, input int stop_k, input int csum_sel);
    int gap;
    wr_cnt = 0; done_cnt = 0; m_idx = 0; m_nbytes = 0; m_xor = 8'h00; m_word = '0;
    exp_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("wvalid_cleared", w_valid, 0);
    for (int k = 0; k < NB; k++) begin
      if (k == stop_k) return;
      if (k == extra_start_k) start = 1'b1;
      send_byte(8'(k), 1'b1);
      start = 1'b0;
      gap = (gap_mode == 0) ? 0 : ((k % 2 == 0) ? 1 : $urandom_range(1, 5));
      repeat (gap) begin @(posedge clk); #1; end
    end
    if (csum_sel == 1) send_byte(m_xor, 1'b0);
    if (csum_sel == 2) send_byte(m_xor ^ 8'h01, 1'b0);
    for (int c = 0; c < 200; c++) begin
      if (done_cnt != 0) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("done_count", done_cnt, 1);
    chk("write_count", wr_cnt, NUM_WORDS);
    chk("writes_pending", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    chk("ready_end", o_ready, 0);
    chk("wvalid_end", w_valid, (csum_sel != 2));
    chk("err_end", err, (csum_sel == 2));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {o_ready, we_a, busy, done, w_valid, err}, 0);
    chk("reset_addr", addr_a, 0);
    chk("reset_din", din_a, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Stream offered while idle must be refused.
    wr_cnt = 0;
    i_valid = 1'b1; i_data = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_ready", o_ready, 0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("idle_no_writes", wr_cnt, 0);

    run_load(0, -1, -1, 0);
    chk("first_addr", first_addr, 0);
    chk("first_din", first_din, 16'h0100);
    chk("last_addr", last_addr, 36);
    chk("last_din", last_din, 16'h4948);
    chk("model_xor", m_xor, 8'h01);

    run_load(1, -1, -1, 0);
    run_load(0, 20, -1, 0);

    // Abort partway through word 20.
    run_load(0, -1, 41, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_writes", wr_cnt, 20);
    chk("abort_pending", exp_q.size(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_ctl", {o_ready, we_a, busy, done, w_valid, err}, 0);
    chk("midreset_addr", addr_a, 0);
    chk("midreset_din", din_a, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_load(0, -1, -1, 0);
    chk("reload_last_addr", last_addr, 36);

`ifdef SVM_LOAD_CHECKSUM_EN
    run_load(1, -1, -1, 1);
    run_load(0, -1, -1, 2);
    run_load(0, -1, -1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
